// File: rtl/led_shift_rx_if.sv
// Serial LED shift-clock bus: transmit-side inputs and the deserializer's parallel results.
// The master drives the serial lines; the slave is the receiving driver model.
interface led_shift_rx_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DATA_W) + 2
);
    logic              sclk_in;
    logic              sdi_in;
    logic              lat_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [CNT_W-1:0]  bit_cnt;
    logic              frame_err;
    logic              sdo;

    modport master (
        output sclk_in, sdi_in, lat_in,
        input  data_out, data_valid, bit_cnt, frame_err, sdo
    );

    modport slave (
        input  sclk_in, sdi_in, lat_in,
        output data_out, data_valid, bit_cnt, frame_err, sdo
    );
endinterface

// File: rtl/led_shift_rx.sv
// Panel-side LED driver model: oversamples sclk/sdi/lat, shifts MSB-first on sclk rise,
// latches the word and checks the frame length on lat rise; sdo cascades the shift MSB.
module led_shift_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = $clog2(DATA_W) + 2
) (
    input logic            clk,
    input logic            rstN,
    led_shift_rx_if.slave  bus
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] lat_sync_q;
    logic                   sclk_prev_q;
    logic                   lat_prev_q;

    logic [DATA_W-1:0]      sr_q,    sr_d;
    logic [DATA_W-1:0]      data_q,  data_d;
    logic                   valid_q, valid_d;
    logic                   err_q,   err_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;

    logic                   sclk_s;
    logic                   sdi_s;
    logic                   lat_s;
    logic                   sclk_rise;
    logic                   lat_rise;

    // sdi goes through the same depth as sclk so the bit seen at the sclk rise is aligned.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            lat_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            lat_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk_in};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0],  bus.sdi_in};
            lat_sync_q  <= {lat_sync_q[SYNC_STAGES-2:0],  bus.lat_in};
            sclk_prev_q <= sclk_s;
            lat_prev_q  <= lat_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign lat_s     = lat_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign lat_rise  = lat_s & ~lat_prev_q;

    always_comb begin
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (sclk_rise) begin
            sr_d = {sr_q[DATA_W-2:0], sdi_s};
        end

        // A coincident shift still lands, but counts toward the following frame.
        if (lat_rise) begin
            data_d  = sr_q;
            valid_d = 1'b1;
            err_d   = (cnt_q != CNT_W'(DATA_W));
            cnt_d   = sclk_rise ? CNT_W'(1) : '0;
        end else if (sclk_rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.bit_cnt    = cnt_q;
    assign bus.frame_err  = err_q;
    assign bus.sdo        = sr_q[DATA_W-1];

endmodule

// File: tb/tb_led_shift_rx.sv
// Directed bench for led_shift_rx: latch results are queued at stimulus time and
// checked by a monitor whenever data_valid pulses; counters/sdo are checked inline.
module tb_led_shift_rx;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rstN;
    int          total;
    int          bad;
    exp_t        exp_q[$];
    logic [15:0] model_sr;

    led_shift_rx_if #(.DATA_W(16), .CNT_W(6)) bus ();

    led_shift_rx #(
        .DATA_W     (16),
        .SYNC_STAGES(2),
        .CNT_W      (6)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // One sclk pulse carrying bit b, then enough settle for the shift to reach the outputs.
    task automatic send_bit(input logic b);
        bus.sdi_in  = b;
        bus.sclk_in = 1'b1;
        tick();
        bus.sclk_in = 1'b0;
        tick();
        tick();
        model_sr = {model_sr[14:0], b};
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input logic check_sdo);
        logic [31:0] v;
        v = w;
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i]);
            if (check_sdo) chk("sdo", {31'd0, bus.sdo}, {31'd0, model_sr[15]});
        end
    endtask

    task automatic pulse_lat();
        bus.lat_in = 1'b1;
        tick();
        bus.lat_in = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Scoreboard monitor: every data_valid cycle must match the next queued latch.
    always @(negedge clk) begin
        if (rstN && bus.data_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL latch: unexpected data_valid, data_out=%h frame_err=%b",
                         bus.data_out, bus.frame_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.data_out !== e.data || bus.frame_err !== e.err) begin
                    bad++;
                    $display("FAIL latch: got data_out=%h frame_err=%b expected data_out=%h frame_err=%b",
                             bus.data_out, bus.frame_err, e.data, e.err);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] sdo_hist;
        total       = 0;
        bad         = 0;
        model_sr    = '0;
        rstN        = 1'b0;
        bus.sclk_in = 1'b0;
        bus.sdi_in  = 1'b0;
        bus.lat_in  = 1'b0;

        #12;
        chk("reset data_out",   {16'd0, bus.data_out},   32'd0);
        chk("reset data_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("reset bit_cnt",    {26'd0, bus.bit_cnt},    32'd0);
        chk("reset frame_err",  {31'd0, bus.frame_err},  32'd0);
        chk("reset sdo",        {31'd0, bus.sdo},        32'd0);
        tick();
        rstN = 1'b1;
        tick();

        // Full frame 0xA5C3
        send_word(32'hA5C3, 16, 1'b1);
        chk("full bit_cnt", {26'd0, bus.bit_cnt}, 32'd16);
        push_exp(16'hA5C3, 1'b0);
        pulse_lat();
        chk("full bit_cnt after lat", {26'd0, bus.bit_cnt}, 32'd0);

        // Short frame: 12 ones -> {3, FFF}
        send_word(32'hFFF, 12, 1'b1);
        chk("short bit_cnt", {26'd0, bus.bit_cnt}, 32'd12);
        push_exp(16'h3FFF, 1'b1);
        pulse_lat();

        // Long frame 0xF1234: the leading F nibble leaves through sdo on shifts 16..19
        for (int i = 19; i >= 0; i--) begin
            logic [31:0] w;
            w = 32'hF1234;
            send_bit(w[i]);
            if (i <= 4 && i >= 1) chk("long sdo overflow", {31'd0, bus.sdo}, 32'd1);
            if (i == 4) sdo_hist = '0;
        end
        chk("long sdo last", {31'd0, bus.sdo}, 32'd0);
        chk("long bit_cnt", {26'd0, bus.bit_cnt}, 32'd20);
        push_exp(16'h1234, 1'b1);
        pulse_lat();

        // Simultaneous sclk/lat rise after 0x8001, extra bit = 1
        send_word(32'h8001, 16, 1'b0);
        push_exp(16'h8001, 1'b0);
        bus.sdi_in  = 1'b1;
        bus.sclk_in = 1'b1;
        bus.lat_in  = 1'b1;
        tick();
        bus.sclk_in = 1'b0;
        bus.lat_in  = 1'b0;
        tick();
        tick();
        tick();
        chk("simul bit_cnt", {26'd0, bus.bit_cnt}, 32'd1);
        // Second latch exposes sr: one bit counted, so a length error
        push_exp(16'h0003, 1'b1);
        pulse_lat();

        // Reset after 7 bits
        send_word(32'h7F, 7, 1'b0);
        chk("pre-reset bit_cnt", {26'd0, bus.bit_cnt}, 32'd7);
        rstN = 1'b0;
        #3;
        chk("mid reset data_out",   {16'd0, bus.data_out},   32'd0);
        chk("mid reset data_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("mid reset bit_cnt",    {26'd0, bus.bit_cnt},    32'd0);
        chk("mid reset frame_err",  {31'd0, bus.frame_err},  32'd0);
        chk("mid reset sdo",        {31'd0, bus.sdo},        32'd0);
        tick();
        rstN     = 1'b1;
        model_sr = '0;
        tick();
        send_word(32'h1357, 16, 1'b1);
        push_exp(16'h1357, 1'b0);
        pulse_lat();

        // Back-to-back latches with no sclk
        push_exp(16'h1357, 1'b1);
        pulse_lat();
        push_exp(16'h1357, 1'b1);
        pulse_lat();
        chk("b2b bit_cnt", {26'd0, bus.bit_cnt}, 32'd0);

        // Long lat high level: a single data_valid only
        push_exp(16'h1357, 1'b1);
        bus.lat_in = 1'b1;
        repeat (10) tick();
        bus.lat_in = 1'b0;
        repeat (6) tick();

        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
